// File: rtl/md5_arbiter.sv
// Round-robin scheduler sharing one md5_core between N_REQ single-block requesters.
// Optional RUN watchdog is compiled in with `define MD5_ARBITER_TIMEOUT_EN.
module md5_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = $clog2(N_REQ),
    parameter int TIMEOUT = 96
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*512-1:0] req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [127:0]         resp_hash,
    output logic                 resp_err,
    output logic                 core_rst,
    output logic [511:0]         core_data,
    input  logic [127:0]         core_hash,
    input  logic                 core_done
);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [ID_W-1:0] rr_q;
    logic [ID_W-1:0] scan_idx;
    logic [ID_W-1:0] grant_id;
    logic            grant_vld;
    logic            tmo_hit;

    // Search upward from the last served requester so it ends up with lowest priority.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = ID_W'((int'(rr_q) + k) % N_REQ);
            if (!grant_vld && req_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_id  = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_vld) state_d = RUN;
            RUN:     if (core_done || tmo_hit) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_q       <= ID_W'(N_REQ - 1);
            core_rst   <= 1'b1;
            core_data  <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_hash  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        core_data <= req_data[int'(grant_id)*512 +: 512];
                        resp_id   <= grant_id;
                        rr_q      <= grant_id;
                        core_rst  <= 1'b0;
                    end
                end
                RUN: begin
                    if (core_done) begin
                        resp_hash  <= core_hash;
                        resp_valid <= 1'b1;
                        core_rst   <= 1'b1;
                    end else if (tmo_hit) begin
                        resp_hash  <= '0;
                        resp_valid <= 1'b1;
                        core_rst   <= 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MD5_ARBITER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // Counter sits at zero outside RUN, so it is cleared on every entry.
    assign tmo_hit = (state_q == RUN) && !core_done && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                resp_err <= 1'b1;
            end else if (state_q == RESP && resp_ready) begin
                resp_err <= 1'b0;
            end
        end
    end
`else
    assign tmo_hit  = 1'b0;
    assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_md5_arbiter.sv
// Directed bench for md5_arbiter with a behavioural md5_core stand-in and a
// transaction-level model compared against the DUT on every cycle.
module tb_md5_arbiter;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 96;
    localparam logic [127:0] H_ABC   = 128'h900150983cd24fb0d6963f7d28e17f72;
    localparam logic [127:0] H_EMPTY = 128'hd41d8cd98f00b204e9800998ecf8427e;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [N_REQ*512-1:0] req_data = '0;
    logic [N_REQ-1:0]     req_ready;
    logic                 resp_valid;
    logic                 resp_ready = 1'b1;
    logic [ID_W-1:0]      resp_id;
    logic [127:0]         resp_hash;
    logic                 resp_err;
    logic                 core_rst;
    logic [511:0]         core_data;
    logic [127:0]         core_hash;
    logic                 core_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    md5_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_hash(resp_hash), .resp_err(resp_err),
        .core_rst(core_rst), .core_data(core_data), .core_hash(core_hash),
        .core_done(core_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] bitrev(input logic [511:0] h);
        return {<<{h}};
    endfunction

    logic [511:0] blk_abc;
    logic [511:0] blk_empty;
    initial begin
        blk_abc   = bitrev({32'h61626380, 416'h0, 32'h18000000, 32'h0});
        blk_empty = bitrev({32'h80000000, 480'h0});
    end

    function automatic logic [511:0] blk_n(input int k);
        return {16{32'h01010101 * k + 32'h00C0FFEE}};
    endfunction

    // Stand-in for md5_core: known digests for the two reference blocks, a mix otherwise.
    function automatic logic [127:0] core_fn(input logic [511:0] d);
        if (d == blk_abc) return H_ABC;
        if (d == blk_empty) return H_EMPTY;
        return d[127:0] ^ {d[250:128], d[255:251]} ^ d[383:256] ^ {d[447:384], d[511:448]};
    endfunction

    // Core stub: done first visible in the 66th cycle after reset release.
    int   ccnt = 0;
    logic stall = 1'b0;
    always @(posedge clk) begin
        if (core_rst) ccnt <= 0;
        else if (ccnt < 1000) ccnt <= ccnt + 1;
    end
    assign core_done = !core_rst && (ccnt >= 65) && !stall;
    assign core_hash = core_fn(core_data);

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: one job in flight, response held until taken.
    logic         m_busy = 1'b0;
    logic         m_rv = 1'b0;
    logic         m_err = 1'b0;
    int           m_tacc = 0;
    int           m_rr = N_REQ - 1;
    int           m_id = 0;
    logic [511:0] m_data = '0;
    logic [127:0] m_hash = '0;

    always @(negedge clk) begin
        int g;
        logic [N_REQ-1:0] exp_ready;
        g = -1;
        exp_ready = '0;
        if (!m_busy && !m_rv) begin
            for (int k = 1; k <= N_REQ; k++) begin
                if (g < 0 && req_valid[(m_rr + k) % N_REQ]) g = (m_rr + k) % N_REQ;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 512'(req_ready), 512'(exp_ready));
        check("core_rst", 512'(core_rst), 512'(!m_busy));
        check("core_data", core_data, m_data);
        check("resp_valid", 512'(resp_valid), 512'(m_rv));
        check("resp_id", 512'(resp_id), 512'(m_id));
        check("resp_hash", 512'(resp_hash), 512'(m_hash));
        check("resp_err", 512'(resp_err), 512'(m_err));

        if (rst) begin
            m_busy = 0; m_rv = 0; m_err = 0; m_rr = N_REQ - 1;
            m_id = 0; m_data = '0; m_hash = '0;
        end else if (g >= 0) begin
            m_busy = 1; m_tacc = cyc; m_id = g; m_rr = g;
            m_data = req_data[g*512 +: 512];
        end else if (m_busy) begin
            if (cyc - m_tacc >= 66 && !stall) begin
                m_busy = 0; m_rv = 1; m_err = 0; m_hash = core_fn(m_data);
            end
`ifdef MD5_ARBITER_TIMEOUT_EN
            else if (cyc - m_tacc == TIMEOUT) begin
                m_busy = 0; m_rv = 1; m_err = 1; m_hash = '0;
            end
`endif
        end else if (m_rv && resp_ready) begin
            m_rv = 0; m_err = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input int id, input logic [511:0] blk, output int t_acc);
        bit got;
        got = 0;
        req_data[id*512 +: 512] = blk;
        req_valid[id] = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                got = 1;
                t_acc = cyc;
            end else begin
                tick();
            end
        end
        check("accept_seen", 512'(got), 512'(1));
        if (!got) t_acc = cyc;
        tick();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output bit got, output int t_resp);
        got = 0;
        t_resp = 0;
        for (int i = 0; i < limit && !got; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                t_resp = cyc;
            end
        end
    endtask

    task automatic do_job(input int id, input logic [511:0] blk, input logic [127:0] exp_hash);
        int t_acc, t_resp;
        bit got;
        accept(id, blk, t_acc);
        wait_resp(200, got, t_resp);
        check("resp_seen", 512'(got), 512'(1));
        check("resp_latency", 512'(t_resp - t_acc), 512'(67));
        check("resp_id_lit", 512'(resp_id), 512'(id));
        check("resp_hash_lit", 512'(resp_hash), 512'(exp_hash));
        check("resp_err_lit", 512'(resp_err), 512'(0));
        tick();
    endtask

    initial begin
        int t_acc, t_resp, t_hs, n, seen;
        int order[5];
        bit got;
        logic [127:0] held;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_core_rst", 512'(core_rst), 512'(1));
        check("reset_resp_valid", 512'(resp_valid), 512'(0));
        tick();

        do_job(0, blk_abc, H_ABC);
        do_job(2, blk_empty, H_EMPTY);
        repeat (2) tick();

        // Round robin with all requesters busy, starting from reset priority.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < N_REQ; k++) req_data[k*512 +: 512] = blk_n(k + 1);
        req_valid = '1;
        n = 0;
        for (int i = 0; i < 600 && n < 5; i++) begin
            @(negedge clk);
            if (req_ready != 0) begin
                for (int k = 0; k < N_REQ; k++) if (req_ready[k]) order[n] = k;
                n++;
            end
        end
        tick();
        req_valid = '0;
        check("rr_grants", 512'(n), 512'(5));
        check("rr_order0", 512'(order[0]), 512'(0));
        check("rr_order1", 512'(order[1]), 512'(1));
        check("rr_order2", 512'(order[2]), 512'(2));
        check("rr_order3", 512'(order[3]), 512'(3));
        check("rr_order4", 512'(order[4]), 512'(0));
        repeat (80) tick();

        // Backpressure: response held, nothing granted until one cycle after handshake.
        resp_ready = 1'b0;
        accept(3, blk_n(9), t_acc);
        wait_resp(200, got, t_resp);
        check("bp_resp_seen", 512'(got), 512'(1));
        held = resp_hash;
        tick();
        req_data[1*512 +: 512] = blk_n(5);
        req_valid[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 512'(resp_valid), 512'(1));
            check("bp_hold_hash", 512'(resp_hash), 512'(held));
            check("bp_no_ready", 512'(req_ready), 512'(0));
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        t_hs = cyc;
        check("hs_no_ready", 512'(req_ready), 512'(0));
        tick();
        @(negedge clk);
        check("post_hs_grant", 512'(req_ready), 512'(4'b0010));
        check("post_hs_gap", 512'(cyc - t_hs), 512'(1));
        tick();
        req_valid[1] = 1'b0;
        repeat (80) tick();

        // Reset in the middle of a job.
        accept(0, blk_abc, t_acc);
        while (cyc < t_acc + 30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("midrun_core_rst", 512'(core_rst), 512'(1));
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("midrun_no_resp", 512'(seen), 512'(0));
        tick();
        do_job(1, blk_abc, H_ABC);

        // Core that never finishes.
        stall = 1'b1;
        accept(2, blk_empty, t_acc);
        wait_resp(200, got, t_resp);
`ifdef MD5_ARBITER_TIMEOUT_EN
        check("tmo_resp_seen", 512'(got), 512'(1));
        check("tmo_latency", 512'(t_resp - t_acc), 512'(TIMEOUT + 1));
        check("tmo_err", 512'(resp_err), 512'(1));
        check("tmo_hash", 512'(resp_hash), 512'(0));
        check("tmo_id", 512'(resp_id), 512'(2));
        tick();
        stall = 1'b0;
        repeat (3) tick();
`else
        check("stall_no_resp", 512'(got), 512'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/md5_arbiter.md
Name: md5_arbiter

Overview:
- Round-robin scheduler that shares one md5_core instance between N_REQ requesters, each submitting one pre-padded 512-bit block.
- Sequences the core: holds it in reset while idle, releases it to hash the granted block, captures the digest on core_done, and returns the digest tagged with the requester ID.
- Sits between the message front-ends and the single hash datapath. Each job is one independent block; there is no chaining.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(N_REQ), width of the requester ID.
- TIMEOUT, 96, maximum cycles in RUN before the watchdog fires (only used when the optional feature is compiled in).

Ports:
- clk  in  1  clock (rising edge)
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  per-requester block available
- req_data  in  N_REQ*512  flattened blocks; requester i uses bits [512*i +: 512]; bit 0 of each slice is the first message bit (MSB of byte 0)
- req_ready  out  N_REQ  one-hot accept strobe
- resp_valid  out  1  digest available
- resp_ready  in  1  consumer accepts digest
- resp_id  out  ID_W  requester that owns the digest
- resp_hash  out  128  digest, byte order as md5_core hash
- resp_err  out  1  watchdog abort flag; constant 0 unless the feature is enabled
- core_rst  out  1  drives md5_core rst
- core_data  out  512  drives md5_core input_data
- core_hash  in  128  from md5_core hash
- core_done  in  1  from md5_core done

Behaviour:
- Reset values: state=IDLE, core_rst=1, core_data=0, req_ready=0, resp_valid=0, resp_id=0, resp_hash=0, resp_err=0, rr pointer=N_REQ-1 (so requester 0 has first priority).
- req_ready is combinational from state, req_valid and rr pointer. All other outputs are registered.
- States: IDLE, RUN, RESP.
- IDLE:
  - core_rst=1.
  - If any req_valid is set, grant the first set bit searching upward from rr+1 with wrap-around. Assert req_ready[g]=1 in that cycle; this is the accept cycle T.
  - At the clock edge: core_data<=slice g, resp_id<=g, rr<=g, core_rst<=0, state->RUN.
  - If no req_valid is set, stay in IDLE.
- RUN:
  - core_rst=0, core_data is held stable.
  - On the first cycle with core_done=1: resp_hash<=core_hash, resp_valid<=1, core_rst<=1, state->RESP.
  - With md5_core, core_done is first seen in cycle T+66, so resp_valid rises in cycle T+67.
  - req_ready is 0 for every requester while in RUN.
- RESP:
  - resp_valid, resp_id, resp_hash and resp_err are held stable until resp_ready=1.
  - On the cycle with resp_valid&&resp_ready: resp_valid<=0, resp_err<=0, state->IDLE.
  - No new grant is made in that same cycle; the earliest next accept is the following cycle. This gives a minimum of one IDLE cycle between jobs so the core sees at least one reset cycle.
- Fairness: after requester g is served, g has lowest priority. A requester that holds req_valid waits at most N_REQ-1 jobs.
- req_valid may drop without being accepted; there is no penalty. req_data is only sampled in the accept cycle.
- Synchronous rst in any state, including mid-RUN, returns everything to reset values. The in-flight job is discarded with no response. core_rst goes high on the next edge.
- core_done=1 seen in IDLE or RESP is ignored.

Optional Feature:
- Macro: MD5_ARBITER_TIMEOUT_EN.
- Enabled:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT with core_done still 0: resp_valid<=1, resp_err<=1, resp_hash<=0, core_rst<=1, state->RESP.
  - The response then handshakes as normal.
- Disabled: no counter logic is built, resp_err is tied to 0, and RUN waits indefinitely for core_done.

Test Plan:
- Requester 0 sends the padded "abc" block (61626380, zeros, length word 18000000 at bits 448..479, zeros); resp_ready held 1 -> req_ready[0] pulses at T, resp_valid at T+67, resp_id=0, resp_hash=900150983cd24fb0d6963f7d28e17f72.
- Requester 2 sends the padded empty message (80000000, rest zero) -> resp_id=2, resp_hash=d41d8cd98f00b204e9800998ecf8427e, resp_err=0.
- All four req_valid held high with distinct blocks -> grants in order 0,1,2,3,0; each resp_hash matches the golden model; no requester is starved.
- resp_ready held 0 for 20 cycles after resp_valid -> outputs stay stable; no req_ready asserted; after the handshake the next grant comes no earlier than one cycle later.
- rst asserted in cycle T+30 of a job -> no resp_valid, core_rst=1 next cycle; a fresh request afterwards produces the correct digest.
- With MD5_ARBITER_TIMEOUT_EN, core_done forced to 0 by the model -> resp_valid with resp_err=1 and resp_hash=0 once the RUN counter reaches TIMEOUT=96; without the macro, resp_valid stays 0 indefinitely.
